mem_requester: RTL and testbench
================================

// Module: mem_requester
// PURPOSE
//  CPU-side initiator for the DDR2 memory bridge, clocked in the cpu_clk domain.
//  - Accepts load/store requests from the CPU pipeline over a valid/ready handshake.
//  - Drives the bridge's strobe/address/width/data interface and waits for transaction_complete.
//  - Right-aligns load data and optionally sign-extends it, then returns a response handshake.
// PARAMETERS
//  TIMEOUT_W       16     width of the completion watchdog counter
//  TIMEOUT_CYCLES  4096   cpu_clk cycles in WAIT_CMPL before the error response (MEM_REQ_TIMEOUT_EN only)
// PORTS
//  cpu_clk                   in   1   sole clock
//  rst_n                     in   1   asynchronous, active-low reset
//  req_valid                 in   1   request present
//  req_ready                 out  1   request accepted when req_valid & req_ready
//  req_we                    in   1   1=store, 0=load
//  req_addr                  in   28  byte address
//  req_width                 in   2   `RAM_WIDTH8/16/32/64
//  req_signed                in   1   sign-extend load result
//  req_wdata                 in   64  store data, right-aligned
//  rsp_valid                 out  1   response present; held until rsp_ready
//  rsp_ready                 in   1   response consumed
//  rsp_rdata                 out  64  load result, right-aligned; 0 for stores and errors
//  rsp_err                   out  1   watchdog expired
//  busy                      out  1   state != IDLE
//  mem_addr, mem_read_addr   out  28  both driven with the captured address
//  mem_width                 out  2   captured width
//  mem_data_in               out  64  captured req_wdata
//  mem_data_out              in   64  bridge read data, left-aligned
//  mem_rstrobe, mem_wstrobe  out  1   single-cycle pulses
//  mem_transaction_complete  in   1   one-cycle pulse from the bridge
//  mem_ready                 in   1   bridge out of reset
// BEHAVIOUR
//  Reset values
//  - All outputs 0; state IDLE; req_ready 0 while in reset.
//  State machine: IDLE -> WAIT_RDY -> ISSUE -> WAIT_CMPL -> RESP -> IDLE
//  - IDLE: req_ready = 1. A handshake captures we/addr/width/signed/wdata into registers -> WAIT_RDY.
//  - WAIT_RDY: stay while mem_ready = 0; else -> ISSUE.
//  - ISSUE: assert exactly one of mem_rstrobe/mem_wstrobe for exactly one cycle -> WAIT_CMPL.
//  - WAIT_CMPL: on mem_transaction_complete, register the formatted result -> RESP.
//  - RESP: rsp_valid = 1 and outputs stable until rsp_ready; on rsp_valid & rsp_ready -> IDLE.
//  Interface rules
//  - mem_addr, mem_read_addr, mem_width and mem_data_in come straight from the capture registers.
//    They stay constant from acceptance until the RESP -> IDLE transition.
//  - Minimum latency: accept at cycle N, strobe at N+2, rsp_valid one cycle after complete.
//  - req_ready = 0 in every state other than IDLE; no request queuing.
//  Load formatting (by width)
//  - 64: rdata = mem_data_out.
//  - 32: mem_data_out[63:32]; 16: mem_data_out[63:48]; 8: mem_data_out[63:56].
//  - Narrow widths are zero-extended, or sign-extended from the field MSB when req_signed = 1.
//  Boundary conditions
//  - Store responses always carry rsp_rdata = 0.
//  - mem_transaction_complete outside WAIT_CMPL is ignored, including a late completion from before a reset.
//  - mem_ready falling in WAIT_CMPL: keep waiting, no re-issue.
//  - Reset mid-transaction: state returns to IDLE immediately and any response is dropped.
// CONFIGURATION
//  MEM_REQ_TIMEOUT_EN defined
//  - Counter clears on entry to WAIT_CMPL and increments each cycle there.
//  - At TIMEOUT_CYCLES-1 with no complete: -> RESP with rsp_err = 1, rsp_rdata = 0.
//  - Complete in the same cycle as expiry wins: rsp_err = 0.
//  MEM_REQ_TIMEOUT_EN undefined
//  - No counter; WAIT_CMPL waits indefinitely; rsp_err tied 0.
// STRUCTURE
//  - Width encodings `RAM_WIDTH* come from the shared io_def.vh; no new shared constants.
//  - State encodings are local to this module.
//  - One sub-module, mem_load_fmt: combinational alignment/extension of mem_data_out
//    from width and signed; its output is registered by this module.
// TESTING
//  - 64-bit store addr 0x0000100, wdata 0x0123456789ABCDEF:
//    exactly one wstrobe; addr stable until complete; rsp_rdata 0, rsp_err 0.
//  - Load w8 signed, mem_data_out 0x80000000_00000000 -> rsp_rdata 0xFFFFFFFF_FFFFFF80;
//    same load unsigned -> 0x80.
//  - Load w32, mem_data_out 0xDEADBEEF_00000000 -> rsp_rdata 0x00000000_DEADBEEF.
//  - mem_ready held 0 for 20 cycles after accept -> no strobe until it rises; req_ready 0 throughout.
//  - MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES 16, no complete -> rsp_err 1 sixteen cycles after entering
//    WAIT_CMPL; a later complete is ignored and the next request works normally.
//  - rst_n pulsed low during WAIT_CMPL -> outputs 0 asynchronously; a post-reset complete pulse
//    yields no rsp_valid.

Source files
------------

// File: rtl/mem_requester_pkg.sv
// Shared widths and load-width codes for the mem_requester slice.
// Width codes come from io_def.vh (`RAM_WIDTH*); fallbacks apply only when that header is absent.
`ifndef RAM_WIDTH8
`define RAM_WIDTH8  2'b00
`define RAM_WIDTH16 2'b01
`define RAM_WIDTH32 2'b10
`define RAM_WIDTH64 2'b11
`endif

package mem_requester_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 64;

    localparam logic [1:0] WIDTH_8  = `RAM_WIDTH8;
    localparam logic [1:0] WIDTH_16 = `RAM_WIDTH16;
    localparam logic [1:0] WIDTH_32 = `RAM_WIDTH32;
    localparam logic [1:0] WIDTH_64 = `RAM_WIDTH64;

endpackage

// File: rtl/mem_load_fmt.sv
// Combinational right-alignment and zero/sign extension of left-aligned bridge read data.
module mem_load_fmt
    import mem_requester_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        width,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] result
);

    // Every narrow field starts at bit 63, so all widths share one extension bit.
    logic ext;
    assign ext = sign_ext & data[DATA_W-1];

    always_comb begin
        result = data;
        case (width)
            WIDTH_8:  result = {{56{ext}}, data[63:56]};
            WIDTH_16: result = {{48{ext}}, data[63:48]};
            WIDTH_32: result = {{32{ext}}, data[63:32]};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/mem_requester.sv
// CPU-side initiator for the DDR2 bridge: one outstanding load/store, strobe, wait, respond.
// Optional completion watchdog enabled by defining MEM_REQ_TIMEOUT_EN.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              cpu_clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_width,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [1:0]        mem_width,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              mem_rstrobe,
    output logic              mem_wstrobe,
    input  logic              mem_transaction_complete,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ISSUE,
        WAIT_CMPL,
        RESP
    } state_t;

    state_t state, state_next;

    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [1:0]        cap_width;
    logic              cap_signed;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] fmt_rdata;
    logic              accept;
    logic              timeout_hit;

    // req_ready is gated by rst_n so it reads 0 while reset is held.
    assign req_ready     = (state == IDLE) & rst_n;
    assign accept        = req_valid & req_ready;
    assign busy          = (state != IDLE);
    assign rsp_valid     = (state == RESP);
    assign mem_rstrobe   = (state == ISSUE) & ~cap_we;
    assign mem_wstrobe   = (state == ISSUE) & cap_we;
    assign mem_addr      = cap_addr;
    assign mem_read_addr = cap_addr;
    assign mem_width     = cap_width;
    assign mem_data_in   = cap_wdata;

`ifdef MEM_REQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_count;

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count <= '0;
        end else if (state == ISSUE) begin
            wd_count <= '0;
        end else if (state == WAIT_CMPL) begin
            wd_count <= wd_count + TIMEOUT_W'(1);
        end
    end

    assign timeout_hit = (state == WAIT_CMPL) &&
                         (wd_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_cfg;
    assign unused_cfg  = ^{TIMEOUT_W[0], TIMEOUT_CYCLES[0]};
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept) state_next = WAIT_RDY;
            WAIT_RDY:  if (mem_ready) state_next = ISSUE;
            ISSUE:     state_next = WAIT_CMPL;
            WAIT_CMPL: if (mem_transaction_complete || timeout_hit) state_next = RESP;
            RESP:      if (rsp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Capture registers only load in IDLE, so the bridge-facing fields hold for the whole transaction.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_width  <= '0;
            cap_signed <= 1'b0;
            cap_wdata  <= '0;
        end else if (accept) begin
            cap_we     <= req_we;
            cap_addr   <= req_addr;
            cap_width  <= req_width;
            cap_signed <= req_signed;
            cap_wdata  <= req_wdata;
        end
    end

    mem_load_fmt u_fmt (
        .data     (mem_data_out),
        .width    (cap_width),
        .sign_ext (cap_signed),
        .result   (fmt_rdata)
    );

    // A completion in the expiry cycle takes priority over the watchdog.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state == WAIT_CMPL) begin
            if (mem_transaction_complete) begin
                rsp_rdata <= cap_we ? '0 : fmt_rdata;
                rsp_err   <= 1'b0;
            end else if (timeout_hit) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end else if (state == RESP && rsp_ready) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester with a response scoreboard and a behavioural bridge.
// Timeout checks are compiled in when MEM_REQ_TIMEOUT_EN is defined.
module tb_mem_requester;
    import mem_requester_pkg::*;

    localparam int BOUND = 200;

    logic        cpu_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [27:0] req_addr = '0;
    logic [1:0]  req_width = '0;
    logic        req_signed = 1'b0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [27:0] mem_addr;
    logic [27:0] mem_read_addr;
    logic [1:0]  mem_width;
    logic [63:0] mem_data_in;
    logic [63:0] mem_data_out = '0;
    logic        mem_rstrobe;
    logic        mem_wstrobe;
    logic        mem_transaction_complete = 1'b0;
    logic        mem_ready = 1'b1;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    mem_requester #(
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .cpu_clk                  (cpu_clk),
        .rst_n                    (rst_n),
        .req_valid                (req_valid),
        .req_ready                (req_ready),
        .req_we                   (req_we),
        .req_addr                 (req_addr),
        .req_width                (req_width),
        .req_signed               (req_signed),
        .req_wdata                (req_wdata),
        .rsp_valid                (rsp_valid),
        .rsp_ready                (rsp_ready),
        .rsp_rdata                (rsp_rdata),
        .rsp_err                  (rsp_err),
        .busy                     (busy),
        .mem_addr                 (mem_addr),
        .mem_read_addr            (mem_read_addr),
        .mem_width                (mem_width),
        .mem_data_in              (mem_data_in),
        .mem_data_out             (mem_data_out),
        .mem_rstrobe              (mem_rstrobe),
        .mem_wstrobe              (mem_wstrobe),
        .mem_transaction_complete (mem_transaction_complete),
        .mem_ready                (mem_ready)
    );

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference load formatting written as an arithmetic/logical shift.
    function automatic logic [63:0] model_load(input logic [63:0] d, input logic [1:0] w,
                                               input logic s);
        int n;
        logic signed [63:0] sd;
        n  = 64;
        if (w == WIDTH_8)  n = 8;
        if (w == WIDTH_16) n = 16;
        if (w == WIDTH_32) n = 32;
        sd = d;
        return s ? 64'(sd >>> (64 - n)) : (d >> (64 - n));
    endfunction

    task automatic apply_stimulus(input string tag, input logic we, input logic [27:0] addr,
                                  input logic [1:0] width, input logic sgn,
                                  input logic [63:0] wdata, input bit expect_rsp,
                                  input logic [63:0] exp_rdata, input logic exp_err);
        int n;
        if (expect_rsp) exp_q.push_back(rsp_t'{rdata: exp_rdata, err: exp_err});
        req_we     = we;
        req_addr   = addr;
        req_width  = width;
        req_signed = sgn;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < BOUND) begin
            step();
            n++;
        end
        check_output({tag, "/req_ready_idle"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        req_wdata = ~wdata;
        req_addr  = ~addr;
        check_output({tag, "/busy_after_accept"}, busy, 1);
        check_output({tag, "/req_ready_busy"}, req_ready, 0);
    endtask

    task automatic wait_strobe(input string tag, input logic we, output int lat);
        lat = 0;
        while (!(mem_rstrobe | mem_wstrobe) && lat < BOUND) begin
            step();
            lat++;
        end
        check_output({tag, "/strobe_kind"}, {mem_wstrobe, mem_rstrobe}, we ? 2'b10 : 2'b01);
    endtask

    task automatic check_response(input string tag);
        rsp_t exp;
        int n;
        n = 0;
        while (!rsp_valid && n < BOUND) begin
            step();
            n++;
        end
        check_output({tag, "/rsp_valid"}, rsp_valid, 1);
        check_output({tag, "/scoreboard_nonempty"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check_output({tag, "/rsp_rdata"}, rsp_rdata, exp.rdata);
            check_output({tag, "/rsp_err"}, rsp_err, exp.err);
            repeat (2) step();
            check_output({tag, "/rsp_held"}, {rsp_valid, rsp_rdata, rsp_err}, {1'b1, exp.rdata, exp.err});
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_output({tag, "/idle_after_rsp"}, {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [27:0] addr,
                          input logic [1:0] width, input logic sgn, input logic [63:0] wdata,
                          input logic [63:0] mdata, input logic [63:0] exp_rdata,
                          input int ready_hold, input bit ready_drop);
        int lat;
        logic quiet;
        if (ready_hold > 0) mem_ready = 1'b0;
        apply_stimulus(tag, we, addr, width, sgn, wdata, 1'b1, exp_rdata, 1'b0);
        if (ready_hold > 0) begin
            quiet = 1'b1;
            repeat (ready_hold) begin
                if (mem_rstrobe || mem_wstrobe || req_ready) quiet = 1'b0;
                step();
            end
            check_output({tag, "/no_strobe_while_not_ready"}, quiet, 1);
            mem_ready = 1'b1;
        end
        wait_strobe(tag, we, lat);
        check_output({tag, "/strobe_latency"}, lat, 1);
        check_output({tag, "/mem_addr"}, {mem_addr, mem_read_addr}, {addr, addr});
        check_output({tag, "/mem_width_data"}, {mem_width, mem_data_in}, {width, wdata});
        step();
        check_output({tag, "/strobe_single"}, {mem_wstrobe, mem_rstrobe}, 2'b00);
        if (ready_drop) begin
            mem_ready = 1'b0;
            quiet = 1'b1;
            repeat (3) begin
                step();
                if (mem_rstrobe || mem_wstrobe || rsp_valid) quiet = 1'b0;
            end
            check_output({tag, "/no_reissue"}, quiet, 1);
            mem_ready = 1'b1;
        end
        check_output({tag, "/addr_stable"}, {mem_addr, mem_width, mem_data_in}, {addr, width, wdata});
        mem_data_out = mdata;
        mem_transaction_complete = 1'b1;
        step();
        mem_transaction_complete = 1'b0;
        mem_data_out = {$urandom, $urandom};
        check_output({tag, "/rsp_one_cycle_after_cmpl"}, rsp_valid, 1);
        check_response(tag);
    endtask

    initial begin
        logic [63:0] d;
        logic [1:0]  codes [4];
        logic [1:0]  w;
        logic        s;
        int          lat;
        int          n;
        logic        quiet;

        codes = '{WIDTH_8, WIDTH_16, WIDTH_32, WIDTH_64};

        #12;
        check_output("reset/outputs",
                     {req_ready, rsp_valid, rsp_err, busy, mem_rstrobe, mem_wstrobe, rsp_rdata, mem_addr},
                     '0);
        step();
        rst_n = 1'b1;
        step();
        check_output("post_reset/req_ready", req_ready, 1);

        mem_transaction_complete = 1'b1;
        step();
        mem_transaction_complete = 1'b0;
        step();
        check_output("idle_stray_cmpl", {rsp_valid, busy}, 2'b00);

        do_txn("store64", 1'b1, 28'h0000100, WIDTH_64, 1'b0, 64'h0123456789ABCDEF,
               64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1'b1);
        do_txn("load8s", 1'b0, 28'h0000200, WIDTH_8, 1'b1, 64'h0,
               64'h80000000_00000000, 64'hFFFFFFFF_FFFFFF80, 0, 1'b0);
        do_txn("load8u", 1'b0, 28'h0000200, WIDTH_8, 1'b0, 64'h0,
               64'h80000000_00000000, 64'h00000000_00000080, 0, 1'b0);
        do_txn("load32", 1'b0, 28'h0000300, WIDTH_32, 1'b0, 64'h0,
               64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF, 0, 1'b0);
        do_txn("load16s_hold", 1'b0, 28'hABCDEF0, WIDTH_16, 1'b1, 64'h5555,
               64'h8001_1234_5678_9ABC, 64'hFFFFFFFF_FFFF8001, 20, 1'b0);
        do_txn("load64", 1'b0, 28'hFFFFFFF, WIDTH_64, 1'b1, 64'h0,
               64'hFEDCBA98_76543210, 64'hFEDCBA98_76543210, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            w = codes[$urandom_range(0, 3)];
            s = 1'($urandom_range(0, 1));
            do_txn("load_rand", 1'b0, 28'($urandom), w, s, 64'h0, d, model_load(d, w, s), 0, 1'b0);
        end

`ifdef MEM_REQ_TIMEOUT_EN
        apply_stimulus("timeout", 1'b0, 28'h0000400, WIDTH_32, 1'b0, 64'h0, 1'b1, 64'h0, 1'b1);
        wait_strobe("timeout", 1'b0, lat);
        step();
        n = 0;
        while (!rsp_valid && n < BOUND) begin
            step();
            n++;
        end
        check_output("timeout/cycles_in_wait", n, 16);
        mem_data_out = 64'hDEADBEEF_00000000;
        mem_transaction_complete = 1'b1;
        step();
        mem_transaction_complete = 1'b0;
        check_response("timeout");
        do_txn("after_timeout", 1'b0, 28'h0000500, WIDTH_32, 1'b0, 64'h0,
               64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF, 0, 1'b0);
`else
        check_output("no_watchdog/rsp_err_tied", rsp_err, 0);
`endif

        apply_stimulus("reset_mid", 1'b0, 28'h0000600, WIDTH_64, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        wait_strobe("reset_mid", 1'b0, lat);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_mid/async_outputs",
                     {req_ready, rsp_valid, busy, mem_rstrobe, mem_wstrobe, mem_addr, mem_width},
                     '0);
        #3;
        rst_n = 1'b1;
        step();
        mem_data_out = 64'h11112222_33334444;
        mem_transaction_complete = 1'b1;
        step();
        mem_transaction_complete = 1'b0;
        quiet = 1'b1;
        repeat (5) begin
            if (rsp_valid || busy) quiet = 1'b0;
            step();
        end
        check_output("reset_mid/late_cmpl_ignored", quiet, 1);

        do_txn("after_reset", 1'b1, 28'h0000700, WIDTH_16, 1'b0, 64'hBEEF,
               64'h0, 64'h0, 0, 1'b0);

        check_output("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
